alu_control: RTL and testbench

Decodes the 2-bit main-control `ALU_OP` and the funct fields of a RISC-V RV32I instruction into the 4-bit operation select for the datapath ALU. It sits between the main control unit / instruction register and the ALU in the execute stage. The decoded code is registered, so the ALU select is valid one cycle after the inputs are presented.

---
 rtl/alu_control.sv | 77 +++++++
 tb/tb_alu_control.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// alu_control: decodes main-control ALU_OP plus funct3/funct7[5] of an RV32I
// instruction into the 4-bit datapath ALU operation select. The result is
// registered, so alu_inst is valid one cycle after the inputs are sampled.
module alu_control #(
  parameter int width_instruction = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [width_instruction-1:0] instruccion,
  input  logic [1:0]                   ALU_OP,
  output logic [3:0]                   alu_inst
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [1:0] CLS_MEM    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_RTYPE  = 2'b10;
  localparam logic [1:0] CLS_ITYPE  = 2'b11;

  logic [2:0] funct3;
  logic       funct7_b5;
  logic [3:0] alu_inst_d;
  logic [3:0] alu_inst_q;

  // Only bit 30 and bits 14:12 matter; the rest of the word is deliberately ignored.
  logic       unused_instr;
  assign unused_instr = ^instruccion;

  assign funct3    = instruccion[14:12];
  assign funct7_b5 = instruccion[30];

  // Combinational decode; every input combination yields a defined code.
  always_comb begin
    alu_inst_d = OP_ADD;
    unique case (ALU_OP)
      CLS_MEM:    alu_inst_d = OP_ADD;
      CLS_BRANCH: alu_inst_d = OP_SUB;
      CLS_RTYPE, CLS_ITYPE: begin
        unique case (funct3)
          3'b000: begin
            // In I-type, bit 30 is part of the immediate: there is no SUBI.
            if (ALU_OP == CLS_RTYPE && funct7_b5) alu_inst_d = OP_SUB;
            else                                  alu_inst_d = OP_ADD;
          end
          3'b001: alu_inst_d = OP_SLL;
          3'b010: alu_inst_d = OP_SLT;
          3'b011: alu_inst_d = OP_SLTU;
          3'b100: alu_inst_d = OP_XOR;
          3'b101: alu_inst_d = funct7_b5 ? OP_SRA : OP_SRL;
          3'b110: alu_inst_d = OP_OR;
          3'b111: alu_inst_d = OP_AND;
          default: alu_inst_d = OP_ADD;
        endcase
      end
      default: alu_inst_d = OP_ADD;
    endcase
  end

  // Output register; synchronous reset forces ADD and discards any pending decode.
  always_ff @(posedge clk) begin
    if (rst) alu_inst_q <= OP_ADD;
    else     alu_inst_q <= alu_inst_d;
  end

  assign alu_inst = alu_inst_q;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: reset behaviour, a directed vector
// table covering every decode class, and hand-written latency/hold/reset cases.
module tb_alu_control;

  logic        clk;
  logic        rst;
  logic [31:0] instruccion;
  logic [1:0]  ALU_OP;
  logic [3:0]  alu_inst;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] instr;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[$];

  alu_control #(.width_instruction(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruccion (instruccion),
    .ALU_OP      (ALU_OP),
    .alu_inst    (alu_inst)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] exp);
    tests++;
    if (alu_inst !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, alu_inst, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs.push_back('{"mem_ffff",    2'b00, 32'hFFFFFFFF, 4'b0010});
    vecs.push_back('{"branch_ffff", 2'b01, 32'hFFFFFFFF, 4'b0110});
    vecs.push_back('{"mem_sub_ins", 2'b00, 32'h40000033, 4'b0010});
    vecs.push_back('{"br_and_ins",  2'b01, 32'h00007033, 4'b0110});
    vecs.push_back('{"r_add",       2'b10, 32'h00000033, 4'b0010});
    vecs.push_back('{"r_sub",       2'b10, 32'h40000033, 4'b0110});
    vecs.push_back('{"r_sll",       2'b10, 32'h00001033, 4'b0011});
    vecs.push_back('{"r_slt",       2'b10, 32'h00002033, 4'b0111});
    vecs.push_back('{"r_sltu",      2'b10, 32'h00003033, 4'b1000});
    vecs.push_back('{"r_xor",       2'b10, 32'h00004033, 4'b0100});
    vecs.push_back('{"r_srl",       2'b10, 32'h00005033, 4'b0101});
    vecs.push_back('{"r_sra",       2'b10, 32'h40005033, 4'b1001});
    vecs.push_back('{"r_or",        2'b10, 32'h00006033, 4'b0001});
    vecs.push_back('{"r_and",       2'b10, 32'h00007033, 4'b0000});
    vecs.push_back('{"r_and_b30",   2'b10, 32'h40007033, 4'b0000});
    vecs.push_back('{"r_xor_b30",   2'b10, 32'h40004033, 4'b0100});
    vecs.push_back('{"r_sll_b30",   2'b10, 32'h40001033, 4'b0011});
    vecs.push_back('{"i_addi_b30",  2'b11, 32'h40000013, 4'b0010});
    vecs.push_back('{"i_addi",      2'b11, 32'h00000013, 4'b0010});
    vecs.push_back('{"i_srai",      2'b11, 32'h40005013, 4'b1001});
    vecs.push_back('{"i_srli",      2'b11, 32'h00005013, 4'b0101});
    vecs.push_back('{"i_xori",      2'b11, 32'h00004013, 4'b0100});
    vecs.push_back('{"i_slli",      2'b11, 32'h00001013, 4'b0011});
    vecs.push_back('{"i_slti",      2'b11, 32'h00002013, 4'b0111});
    vecs.push_back('{"i_sltiu",     2'b11, 32'h00003013, 4'b1000});
    vecs.push_back('{"i_ori",       2'b11, 32'h00006013, 4'b0001});
    vecs.push_back('{"i_andi_b30",  2'b11, 32'h40007013, 4'b0000});
    vecs.push_back('{"dontcare",    2'b10, 32'hBFFF8FCC, 4'b0010});
    vecs.push_back('{"dontcare_sub",2'b10, 32'h40007033 ^ 32'h00007000, 4'b0110});

    // Reset held for two edges while the inputs would decode to AND.
    rst         = 1'b1;
    ALU_OP      = 2'b10;
    instruccion = 32'h00007033;
    step();
    step();
    check("reset_value", 4'b0010);
    rst = 1'b0;
    step();
    check("reset_release_and", 4'b0000);

    // Directed vector table, one result per edge.
    foreach (vecs[i]) begin
      ALU_OP      = vecs[i].op;
      instruccion = vecs[i].instr;
      step();
      check(vecs[i].name, vecs[i].exp);
    end

    // Hold: a mid-cycle input change is not visible until the next edge.
    ALU_OP      = 2'b10;
    instruccion = 32'h00000033;
    step();
    check("hold_add", 4'b0010);
    #3;
    instruccion = 32'h40000033;
    #2;
    check("hold_mid_cycle", 4'b0010);
    step();
    check("hold_after_edge", 4'b0110);

    // Mid-stream reset discards the pending decode.
    ALU_OP      = 2'b10;
    instruccion = 32'h00007033;
    rst         = 1'b1;
    step();
    check("midstream_reset", 4'b0010);
    rst         = 1'b0;
    instruccion = 32'h40005033;
    step();
    check("post_reset_sra", 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
